seg_mux_driver: RTL and testbench
=================================

Name: seg_mux_driver

Overview:
- Parametrised time-multiplexed 7-segment driver for NUM_DIGITS common-anode digits. Successor to the stopwatch display stage.
- Scans digits round-robin with a programmable refresh divider and a ghost-suppression blanking window.
- Supports per-digit decimal points and leading-zero suppression.
- In adjust mode it blinks a selectable subset of digits, using the external 1 Hz blink clock.
- Sits between the stopwatch counters and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be >= 1.
- REFRESH_DIV, 50000: clk cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 500: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV. A value of 0 disables blanking.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digits  in  4*NUM_DIGITS  BCD values; digit i at [4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit
- blink  in  1  1 Hz blink clock; low = blink-off phase
- adj  in  1  adjust mode enable
- adj_mask  in  NUM_DIGITS  digits that blink while adj = 1
- lz_en  in  1  leading-zero suppression enable
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  anodes, active-low, at most one low
- frame  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: div_cnt = 0, idx = 0, seg = 7'h7F, dp = 1, an = all ones, frame = 0.
  - Reset asserted mid-scan forces this state on the next edge.
  - Scanning resumes at digit 0, slot cycle 0.
- Refresh counter:
  - div_cnt counts 0 .. REFRESH_DIV-1, then wraps to 0.
  - On the wrap, idx advances by 1 modulo NUM_DIGITS: NUM_DIGITS-1 -> 0, with no idle slot.
  - With NUM_DIGITS = 1, idx stays 0.
- Output registering: all outputs are registered and computed from the current idx, div_cnt and inputs. Outputs lag the state by exactly 1 cycle. An input change is visible on the outputs 1 cycle later while that digit is active.
- Decode (digits 0-9, active-low {g..a}):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - Values 10-15 give 7F (blank). No latch and no hold of the previous value.
- Digit blanked when any of the following holds:
  - (a) div_cnt < BLANK_CYCLES;
  - (b) adj = 1, blink = 0 and adj_mask[idx] = 1;
  - (c) lz_en = 1, idx > 0, and digit idx and every higher digit are 0.
    - Digit 0 is never suppressed by (c).
    - Decimal points do not stop suppression.
- Blanked digit: an = all ones, seg = 7F, dp = 1.
- Otherwise: an = ~(1 << idx), seg = decode(digit idx), dp = ~dp_in[idx].
- adj = 0: blink and adj_mask are ignored, so every unsuppressed digit is steadily lit.
- blink is sampled synchronously; it is never used as a clock.
- frame: registered and high for exactly the one cycle in which the outputs reflect idx = 0, div_cnt = 0. The period is NUM_DIGITS*REFRESH_DIV cycles.
- Invariant: an is never more than one-cold. Any change of idx produces at least one cycle of an = all ones, guaranteed when BLANK_CYCLES >= 1.

Test Plan:
Bench settings: NUM_DIGITS = 4, REFRESH_DIV = 8, BLANK_CYCLES = 2.
1. Scan order: rst for 2 cycles, then release with digits = 16'h1234, lz_en = 0, adj = 0.
   - Required: an steps 1111 (2 cycles), 1110 (6 cycles) with seg = 19 for digit "4", then 1101 with seg = 30.
   - frame pulses every 32 cycles.
2. Invalid digit: digits = 16'h00A7 -> the digit 1 slot shows an = 1101 with seg = 7F.
3. Leading-zero suppression: lz_en = 1 with digits = 16'h0005.
   - Required: digits 3, 2 and 1 keep an = 1111; digit 0 shows seg = 12.
   - With digits = 16'h0000, only digit 0 lights, with seg = 40.
4. Adjust blink: adj = 1, adj_mask = 4'b1100, blink = 0.
   - Required: digits 3 and 2 stay dark; digits 1 and 0 light normally.
   - blink = 1 lights all four; adj = 0 with blink = 0 lights all four.
5. Decimal point: dp_in = 4'b0100 -> dp = 0 only while an = 1011; dp = 1 during the blank window.
6. Reset mid-scan: assert rst at idx = 2, div_cnt = 5.
   - Required: on the next edge an = 1111, seg = 7F and dp = 1.
   - After release the scan restarts at digit 0, and frame fires 1 cycle after release.

Source files
------------

// File: rtl/seg_mux_if.sv
// Display-side bundle between the stopwatch counters and the segment driver.
// master: the producer of digit data and mode controls; slave: the driver.
interface seg_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blink;
  logic                    adj;
  logic [NUM_DIGITS-1:0]   adj_mask;
  logic                    lz_en;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame;

  modport master (
    output digits, dp_in, blink, adj, adj_mask, lz_en,
    input  seg, dp, an, frame
  );

  modport slave (
    input  digits, dp_in, blink, adj, adj_mask, lz_en,
    output seg, dp, an, frame
  );
endinterface

// File: rtl/seg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver with ghost-suppression
// blanking, leading-zero suppression and adjust-mode blinking.
module seg_mux_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic     clk,
  input logic     rst,
  seg_mux_if.slave bus
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]       div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic [3:0] cur_digit;
  logic       win_blank, blink_blank, lz_blank;

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show nothing.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Slot divider and round-robin digit index.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_cnt_q == CntMax) begin
      div_cnt_d = '0;
      idx_d     = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Output decode for the digit currently in its slot.
  always_comb begin
    cur_digit   = bus.digits[{idx_q, 2'b00} +: 4];
    win_blank   = 32'(div_cnt_q) < BLANK_CYCLES;
    blink_blank = bus.adj && !bus.blink && bus.adj_mask[idx_q];
    // Suppressed only when this digit and everything above it is zero.
    lz_blank    = bus.lz_en && (idx_q != '0);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (i >= int'(idx_q) && bus.digits[4*i +: 4] != 4'd0) lz_blank = 1'b0;
    end

    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    frame_d = (div_cnt_q == '0) && (idx_q == '0);
    if (!(win_blank || blink_blank || lz_blank)) begin
      an_d[idx_q] = 1'b0;
      seg_d       = decode(cur_digit);
      dp_d        = ~bus.dp_in[idx_q];
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.an    = an_q;
  assign bus.frame = frame_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver: literal checks at hand-picked scan
// positions plus a per-cycle comparison against a position-based model.
module tb_seg_mux_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_mux_if #(.NUM_DIGITS(N)) bus ();

  seg_mux_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;
  int k     = 0;

  logic [6:0] dec_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, got, exp, k);
    end
  endtask

  // Model: outputs after each edge depend only on how many cycles have
  // elapsed since reset and on the inputs present at that edge.
  int         pos    = 0;
  logic       mvalid = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic       exp_frame;

  always @(posedge clk) begin
    int slot, cyc, dval;
    logic off;
    if (rst) begin
      exp_an    <= 4'hF;
      exp_seg   <= 7'h7F;
      exp_dp    <= 1'b1;
      exp_frame <= 1'b0;
      pos       <= 0;
      mvalid    <= 1'b1;
    end else begin
      slot = (pos / RD) % N;
      cyc  = pos % RD;
      dval = int'((bus.digits >> (4 * slot)) & 16'hF);
      off  = (cyc < BC)
          || (bus.adj && !bus.blink && bus.adj_mask[slot])
          || (bus.lz_en && slot > 0 && (bus.digits >> (4 * slot)) == 16'h0);
      exp_an    <= off ? 4'hF : ~(4'b0001 << slot);
      exp_seg   <= off ? 7'h7F : dec_tab[dval];
      exp_dp    <= off ? 1'b1 : ~bus.dp_in[slot];
      exp_frame <= (pos % (N * RD)) == 0;
      pos       <= pos + 1;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_an", 32'(bus.an), 32'(exp_an));
      chk("model_seg", 32'(bus.seg), 32'(exp_seg));
      chk("model_dp", 32'(bus.dp), 32'(exp_dp));
      chk("model_frame", 32'(bus.frame), 32'(exp_frame));
    end
  end

  // Advance to the sample where outputs reflect scan position `target`.
  task automatic adv_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    bus.digits   = 16'h1234;
    bus.dp_in    = 4'b0000;
    bus.blink    = 1'b0;
    bus.adj      = 1'b0;
    bus.adj_mask = 4'b0000;
    bus.lz_en    = 1'b0;

    // 1. Reset, then scan order and frame period.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_frame", 32'(bus.frame), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    k = 0;
    chk("t1_frame0", 32'(bus.frame), 32'h1);
    chk("t1_blank0", 32'(bus.an), 32'hF);
    adv_to(1);  chk("t1_blank1", 32'(bus.an), 32'hF);
    chk("t1_frame1", 32'(bus.frame), 32'h0);
    adv_to(2);  chk("t1_an_d0", 32'(bus.an), 32'hE);
    chk("t1_seg_d0", 32'(bus.seg), 32'h19);
    adv_to(7);  chk("t1_an_d0_end", 32'(bus.an), 32'hE);
    adv_to(8);  chk("t1_blank_d1", 32'(bus.an), 32'hF);
    adv_to(10); chk("t1_an_d1", 32'(bus.an), 32'hD);
    chk("t1_seg_d1", 32'(bus.seg), 32'h30);
    adv_to(18); chk("t1_seg_d2", 32'(bus.seg), 32'h24);
    adv_to(26); chk("t1_an_d3", 32'(bus.an), 32'h7);
    chk("t1_seg_d3", 32'(bus.seg), 32'h79);
    adv_to(31); chk("t1_frame31", 32'(bus.frame), 32'h0);
    adv_to(32); chk("t1_frame32", 32'(bus.frame), 32'h1);

    // 2. Non-BCD digit renders blank while its anode is still driven.
    bus.digits = 16'h00A7;
    adv_to(34); chk("t2_seg_7", 32'(bus.seg), 32'h78);
    adv_to(42); chk("t2_an_d1", 32'(bus.an), 32'hD);
    chk("t2_seg_A", 32'(bus.seg), 32'h7F);

    // 3. Leading-zero suppression.
    bus.lz_en  = 1'b1;
    bus.digits = 16'h0005;
    adv_to(66); chk("t3_an_d0", 32'(bus.an), 32'hE);
    chk("t3_seg_5", 32'(bus.seg), 32'h12);
    adv_to(74); chk("t3_sup_d1", 32'(bus.an), 32'hF);
    adv_to(82); chk("t3_sup_d2", 32'(bus.an), 32'hF);
    adv_to(90); chk("t3_sup_d3", 32'(bus.an), 32'hF);
    bus.digits = 16'h0000;
    adv_to(98); chk("t3_zero_an", 32'(bus.an), 32'hE);
    chk("t3_zero_seg", 32'(bus.seg), 32'h40);
    adv_to(106); chk("t3_zero_d1", 32'(bus.an), 32'hF);

    // 4. Adjust-mode blinking.
    adv_to(122);
    bus.lz_en    = 1'b0;
    bus.digits   = 16'h1234;
    bus.adj      = 1'b1;
    bus.adj_mask = 4'b1100;
    bus.blink    = 1'b0;
    adv_to(130); chk("t4_d0_lit", 32'(bus.an), 32'hE);
    adv_to(138); chk("t4_d1_lit", 32'(bus.an), 32'hD);
    adv_to(146); chk("t4_d2_dark", 32'(bus.an), 32'hF);
    adv_to(154); chk("t4_d3_dark", 32'(bus.an), 32'hF);
    bus.blink = 1'b1;
    adv_to(178); chk("t4_on_d2", 32'(bus.an), 32'hB);
    adv_to(186); chk("t4_on_d3", 32'(bus.an), 32'h7);
    bus.adj   = 1'b0;
    bus.blink = 1'b0;
    adv_to(210); chk("t4_noadj_d2", 32'(bus.an), 32'hB);
    adv_to(218); chk("t4_noadj_d3", 32'(bus.an), 32'h7);

    // 5. Decimal point follows its digit and the blank window.
    bus.dp_in = 4'b0100;
    adv_to(226); chk("t5_dp_d0", 32'(bus.dp), 32'h1);
    adv_to(241); chk("t5_dp_blank", 32'(bus.dp), 32'h1);
    adv_to(242); chk("t5_dp_lit", 32'(bus.dp), 32'h0);
    chk("t5_dp_an", 32'(bus.an), 32'hB);
    adv_to(250); chk("t5_dp_d3", 32'(bus.dp), 32'h1);

    // 6. Reset with the scan state at idx 2, div_cnt 5.
    adv_to(276); chk("t6_pre_an", 32'(bus.an), 32'hB);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_an", 32'(bus.an), 32'hF);
    chk("t6_rst_seg", 32'(bus.seg), 32'h7F);
    chk("t6_rst_dp", 32'(bus.dp), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    k = 0;
    chk("t6_frame", 32'(bus.frame), 32'h1);
    adv_to(2); chk("t6_restart_an", 32'(bus.an), 32'hE);
    adv_to(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
